// File: rtl/dtg_pkg.sv
// Shared constants and types for the dtg display timing generator.
// Defaults describe 1024x768 @ 60 Hz on a 65 MHz pixel clock.
package dtg_pkg;

  localparam int unsigned COORD_W = 12;
  localparam int unsigned WORLD_W = 7;
  localparam int unsigned WORLD_ROW_DIV = 6;

  localparam int unsigned DEF_H_ACTIVE = 1024;
  localparam int unsigned DEF_H_FP     = 24;
  localparam int unsigned DEF_H_SYNC   = 136;
  localparam int unsigned DEF_H_BP     = 160;
  localparam int unsigned DEF_V_ACTIVE = 768;
  localparam int unsigned DEF_V_FP     = 3;
  localparam int unsigned DEF_V_SYNC   = 6;
  localparam int unsigned DEF_V_BP     = 29;
  localparam bit          DEF_SYNC_POL = 1'b0;

  localparam int unsigned H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int unsigned HS_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int unsigned HS_END   = HS_START + DEF_H_SYNC - 1;
  localparam int unsigned VS_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int unsigned VS_END   = VS_START + DEF_V_SYNC - 1;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [WORLD_W-1:0] world_t;

endpackage

// File: rtl/dtg_if.sv
// Video timing bundle from dtg to the pixel logic.
// World coordinate signals exist only when DTG_WORLD_COORD_EN is defined.
interface dtg_if;
  import dtg_pkg::*;

  logic   horiz_sync;
  logic   vert_sync;
  logic   video_on;
  logic   frame_start;
  coord_t pixel_column;
  coord_t pixel_row;
`ifdef DTG_WORLD_COORD_EN
  world_t world_column;
  world_t world_row;
`endif

  modport master (
`ifdef DTG_WORLD_COORD_EN
    output world_column, world_row,
`endif
    output horiz_sync, vert_sync, video_on, frame_start, pixel_column, pixel_row
  );

  modport slave (
`ifdef DTG_WORLD_COORD_EN
    input world_column, world_row,
`endif
    input horiz_sync, vert_sync, video_on, frame_start, pixel_column, pixel_row
  );

endinterface

// File: rtl/dtg_axis.sv
// One timing axis: a wrapping counter with active, sync-window and last decodes.
module dtg_axis
  import dtg_pkg::*;
#(
  parameter int unsigned ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned FP     = DEF_H_FP,
  parameter int unsigned SYNC   = DEF_H_SYNC,
  parameter int unsigned BP     = DEF_H_BP
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   en_i,
  output coord_t cnt_o,
  output logic   active_o,
  output logic   sync_window_o,
  output logic   last_o
);

  localparam int unsigned Total     = ACTIVE + FP + SYNC + BP;
  localparam int unsigned SyncStart = ACTIVE + FP;
  localparam int unsigned SyncEnd   = SyncStart + SYNC - 1;

  coord_t cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = last_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o         = cnt_q;
  assign last_o        = (cnt_q == coord_t'(Total - 1));
  assign active_o      = (cnt_q < coord_t'(ACTIVE));
  assign sync_window_o = (cnt_q >= coord_t'(SyncStart)) && (cnt_q <= coord_t'(SyncEnd));

endmodule

// File: rtl/dtg.sv
// Display timing generator: registered sync, blanking and pixel coordinates.
// Define DTG_WORLD_COORD_EN to add world_column/world_row (column/8, row/6).
module dtg
  import dtg_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          SYNC_POL = DEF_SYNC_POL
) (
  input  logic clock,
  input  logic reset,
  dtg_if.master vid_io
);

  coord_t h_cnt, v_cnt;
  logic   h_act, v_act, h_sw, v_sw, h_last, v_last;

  dtg_axis #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h_axis (
    .clk_i(clock), .rst_i(reset), .en_i(1'b1),
    .cnt_o(h_cnt), .active_o(h_act), .sync_window_o(h_sw), .last_o(h_last)
  );

  dtg_axis #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v_axis (
    .clk_i(clock), .rst_i(reset), .en_i(h_last),
    .cnt_o(v_cnt), .active_o(v_act), .sync_window_o(v_sw), .last_o(v_last)
  );

  coord_t col_q, col_d, row_q, row_d;
  logic   von_q, von_d, fs_q, fs_d, hs_q, hs_d, vs_q, vs_d;

  always_comb begin
    col_d = h_cnt;
    row_d = v_cnt;
    von_d = h_act && v_act;
    fs_d  = (h_cnt == '0) && (v_cnt == '0);
    hs_d  = h_sw ? SYNC_POL : ~SYNC_POL;
    vs_d  = v_sw ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
      von_q <= 1'b0;
      fs_q  <= 1'b0;
      hs_q  <= ~SYNC_POL;
      vs_q  <= ~SYNC_POL;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      von_q <= von_d;
      fs_q  <= fs_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
    end
  end

  assign vid_io.pixel_column = col_q;
  assign vid_io.pixel_row    = row_q;
  assign vid_io.video_on     = von_q;
  assign vid_io.frame_start  = fs_q;
  assign vid_io.horiz_sync   = hs_q;
  assign vid_io.vert_sync    = vs_q;

`ifdef DTG_WORLD_COORD_EN
  // sub_q tracks v_cnt mod 6 and wrow_q tracks v_cnt / 6, so no divider is needed.
  logic [2:0] sub_q, sub_d;
  world_t     wrow_q, wrow_d, wcol_out_q, wcol_out_d, wrow_out_q, wrow_out_d;

  always_comb begin
    sub_d  = sub_q;
    wrow_d = wrow_q;
    if (h_last) begin
      if (v_last) begin
        sub_d  = '0;
        wrow_d = '0;
      end else if (sub_q == 3'(WORLD_ROW_DIV - 1)) begin
        sub_d = '0;
        if (v_act && (wrow_q != '1)) begin
          wrow_d = wrow_q + 1'b1;
        end
      end else begin
        sub_d = sub_q + 1'b1;
      end
    end
    wcol_out_d = von_d ? h_cnt[9:3] : '0;
    wrow_out_d = von_d ? wrow_q : '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sub_q      <= '0;
      wrow_q     <= '0;
      wcol_out_q <= '0;
      wrow_out_q <= '0;
    end else begin
      sub_q      <= sub_d;
      wrow_q     <= wrow_d;
      wcol_out_q <= wcol_out_d;
      wrow_out_q <= wrow_out_d;
    end
  end

  assign vid_io.world_column = wcol_out_q;
  assign vid_io.world_row    = wrow_out_q;
`endif

endmodule

// File: tb/tb_dtg.sv
// Scoreboard bench for dtg: a full-size and a shrunken instance, random resets.
// World outputs are checked when DTG_WORLD_COORD_EN is defined.
module tb_dtg;

  typedef struct packed {
    logic [11:0] col;
    logic [11:0] row;
    logic        von;
    logic        fs;
    logic        hs;
    logic        vs;
    logic [6:0]  wc;
    logic [6:0]  wr;
  } exp_t;

  logic       clock = 1'b0;
  logic [1:0] rst;
  int         n_tests = 0;
  int         n_fail  = 0;
  exp_t       q_exp[2][$];

  always #5 clock = ~clock;

  dtg_if if_f ();
  dtg_if if_s ();

  dtg u_full (
    .clock (clock),
    .reset (rst[0]),
    .vid_io(if_f)
  );

  // Shrunken timing (64 x 44) so whole frames fit in the run; active-high sync.
  dtg #(
    .H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(12),
    .V_ACTIVE(30), .V_FP(3), .V_SYNC(6), .V_BP(5),
    .SYNC_POL(1'b1)
  ) u_small (
    .clock (clock),
    .reset (rst[1]),
    .vid_io(if_s)
  );

  // Expected outputs t cycles after reset release (t < 0: held in reset).
  function automatic exp_t model(int k, int t);
    int ha, hfp, hsw, hbp, va, vfp, vsw, vbp, ht, vt, h, v;
    bit pol;
    exp_t e;
    if (k == 0) begin
      ha = 1024; hfp = 24; hsw = 136; hbp = 160;
      va = 768;  vfp = 3;  vsw = 6;   vbp = 29;  pol = 1'b0;
    end else begin
      ha = 40; hfp = 4; hsw = 8; hbp = 12;
      va = 30; vfp = 3; vsw = 6; vbp = 5;  pol = 1'b1;
    end
    e = '0;
    if (t < 0) begin
      e.hs = ~pol;
      e.vs = ~pol;
      return e;
    end
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    h = t % ht;
    v = (t / ht) % vt;
    e.col = 12'(h);
    e.row = 12'(v);
    e.von = (h < ha) && (v < va);
    e.fs  = (h == 0) && (v == 0);
    e.hs  = (h >= ha + hfp && h < ha + hfp + hsw) ? pol : ~pol;
    e.vs  = (v >= va + vfp && v < va + vfp + vsw) ? pol : ~pol;
    if (e.von) begin
      e.wc = 7'(h / 8);
      e.wr = 7'(v / 6);
    end
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(input string tag, input exp_t e, input exp_t a);
    chk({tag, ".pixel_column"}, int'(a.col), int'(e.col));
    chk({tag, ".pixel_row"},    int'(a.row), int'(e.row));
    chk({tag, ".video_on"},     int'(a.von), int'(e.von));
    chk({tag, ".frame_start"},  int'(a.fs),  int'(e.fs));
    chk({tag, ".horiz_sync"},   int'(a.hs),  int'(e.hs));
    chk({tag, ".vert_sync"},    int'(a.vs),  int'(e.vs));
`ifdef DTG_WORLD_COORD_EN
    chk({tag, ".world_column"}, int'(a.wc), int'(e.wc));
    chk({tag, ".world_row"},    int'(a.wr), int'(e.wr));
`endif
  endtask

  // Monitor: the generator presents a new output every cycle.
  initial begin
    exp_t a;
    forever begin
      @(negedge clock);
      if (q_exp[0].size() > 0) begin
        a = '0;
        a.col = if_f.pixel_column;  a.row = if_f.pixel_row;
        a.von = if_f.video_on;      a.fs  = if_f.frame_start;
        a.hs  = if_f.horiz_sync;    a.vs  = if_f.vert_sync;
`ifdef DTG_WORLD_COORD_EN
        a.wc  = if_f.world_column;  a.wr  = if_f.world_row;
`endif
        cmp("full", q_exp[0].pop_front(), a);
      end
      if (q_exp[1].size() > 0) begin
        a = '0;
        a.col = if_s.pixel_column;  a.row = if_s.pixel_row;
        a.von = if_s.video_on;      a.fs  = if_s.frame_start;
        a.hs  = if_s.horiz_sync;    a.vs  = if_s.vert_sync;
`ifdef DTG_WORLD_COORD_EN
        a.wc  = if_s.world_column;  a.wr  = if_s.world_row;
`endif
        cmp("small", q_exp[1].pop_front(), a);
      end
    end
  end

  // Stimulus: reset 5 clocks, long first run, then random mid-frame resets.
  initial begin
    int t[2];
    int run[2];
    int hold[2];
    int nrel[2];
    rst  = 2'b11;
    t    = '{-1, -1};
    run  = '{0, 0};
    hold = '{4, 4};
    nrel = '{0, 0};
    repeat (28000) begin
      @(posedge clock);
      for (int k = 0; k < 2; k++) begin
        if (rst[k]) t[k] = -1;
        else t[k]++;
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        if (rst[k]) begin
          if (hold[k] == 0) begin
            rst[k] = 1'b0;
            if (nrel[k] == 0) run[k] = (k == 0) ? 20000 : 9000;
            else run[k] = (k == 0) ? int'($urandom_range(1, 4000)) : int'($urandom_range(1, 3000));
            nrel[k]++;
          end else begin
            hold[k]--;
          end
        end else if (run[k] == 0) begin
          rst[k]  = 1'b1;
          t[k]    = -1;
          hold[k] = int'($urandom_range(0, 4));
        end else begin
          run[k]--;
        end
        q_exp[k].push_back(model(k, t[k]));
      end
    end
    @(negedge clock);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dtg.md
Name: dtg

Overview:
- Display timing generator for the 1024x768 @ 60 Hz video path.
- Produces pixel_row and pixel_column for the bot icon and world-map pixel logic, plus video_on, horizontal sync, vertical sync and a frame-start pulse.
- Runs on the 65 MHz pixel clock.
- Coordinates are 12 bits wide, matching the pixel_row/pixel_column inputs of the icon logic (column/8, row/6 gives 128x128 world cells).

Parameters:
- H_ACTIVE, 1024, visible columns
- H_FP, 24, horizontal front porch (clocks)
- H_SYNC, 136, horizontal sync width
- H_BP, 160, horizontal back porch
- V_ACTIVE, 768, visible rows
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vertical sync width
- V_BP, 29, vertical back porch
- SYNC_POL, 0, sync active level (0 = active-low)

Ports:
- clock  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- horiz_sync  out  1  horizontal sync, active level SYNC_POL
- vert_sync  out  1  vertical sync, active level SYNC_POL
- video_on  out  1  high while (pixel_column, pixel_row) is inside the visible area
- pixel_column  out  12  current column, 0..H_TOTAL-1
- pixel_row  out  12  current row, 0..V_TOTAL-1
- frame_start  out  1  one-clock pulse while outputs show (0,0)
- world_column  out  7  (DTG_WORLD_COORD_EN only) pixel_column/8
- world_row  out  7  (DTG_WORLD_COORD_EN only) pixel_row/6

Behaviour:
- One clock; reset is asynchronous and active-high.
- Derived constants: H_TOTAL = sum of H_* = 1344; V_TOTAL = sum of V_* = 806.
- Internal counters:
  - h_cnt runs 0..H_TOTAL-1 and increments every clock.
  - At H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - v_cnt wraps to 0 when both counters are at their final values (h=1343, v=805).
- All outputs are registered and show the counter state of the previous cycle (1-clock latency).
- Reset asynchronously forces:
  - h_cnt = v_cnt = 0
  - pixel_column = pixel_row = 0
  - video_on = 0, frame_start = 0
  - horiz_sync and vert_sync at the inactive level (~SYNC_POL)
  - world outputs = 0
- First clock edge after reset release: outputs show (0,0), video_on = 1, frame_start = 1.
- video_on = (h < H_ACTIVE) && (v < V_ACTIVE).
- horiz_sync is active for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 1048..1183.
- vert_sync is active for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 771..776, across whole lines.
- Coordinates are output unmasked during blanking; consumers qualify them with video_on.
- Reset asserted mid-frame: takes effect immediately, with no partial-line completion.
- Counters never exceed TOTAL-1; there are no illegal states.

Optional Feature:
- Macro: DTG_WORLD_COORD_EN.
- Defined:
  - world_column = h_cnt[9:3], registered alongside pixel_column.
  - world_row comes from a mod-6 line sub-counter (0..5) plus a 7-bit row counter, with no divider.
    - The sub-counter advances on each h wrap.
    - The row counter increments when the sub-counter wraps from 5 to 0.
    - Both clear on v wrap and on reset.
    - The row counter holds at 127 during vertical blanking (v ≥ 768).
  - Both world outputs are forced to 0 when video_on = 0.
- Undefined: world ports and the sub-counter logic are absent, and the block has no divide logic.

Decomposition:
- Package dtg_pkg holds:
  - default timing constants
  - derived H_TOTAL, V_TOTAL, HS_START, HS_END, VS_START, VS_END
  - the coordinate width constant (12)
- One natural sub-module, dtg_axis:
  - parameterised by ACTIVE/FP/SYNC/BP and count enable
  - outputs count, active, sync_window, last
  - instantiated twice: horizontal with enable tied high, vertical enabled by the horizontal last.

Test Plan:
- Reset sequence: reset high for 5 clocks, release → next edge pixel_column=0, pixel_row=0, video_on=1, frame_start=1; the following edge pixel_column=1, frame_start=0.
- Line wrap: pixel_column=1343, pixel_row=10 → next cycle pixel_column=0, pixel_row=11; video_on falls at column 1024 and rises at column 0.
- Horizontal sync: horiz_sync low exactly for columns 1048..1183, 136 clocks per line, high elsewhere.
- Vertical sync and frame: vert_sync low for rows 771..776 (8064 clocks); frame_start period 1,083,264 clocks.
- Mid-frame reset: assert reset at column 500, row 300 → all outputs reach reset values within the same cycle, with no clock edge needed; restart at (0,0).
- World coordinates (DTG_WORLD_COORD_EN):
  - row 5 → world_row 0; row 6 → 1; row 767 → 127
  - column 1023 → world_column 127
  - row 780 → both world outputs 0
